// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: round-robin arbiter that serialises bit-wise load/clear/set/
// toggle operations from N_REQ requesters onto one shared WIDTH-bit register
// bank. A winning requester may lock the bank and keep it for a burst.
module ff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [WIDTH*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         q,
    output logic [OW-1:0]            owner,
    output logic                     locked
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              locked_q, locked_d;

    logic [1:0]        op_s [N_REQ];
    logic [WIDTH-1:0]  wd_s [N_REQ];
    logic              found_s;
    logic [OW-1:0]     win_s;

    // Bit-wise D/SR/T style update of the bank: load, clear-mask, set-mask, toggle-mask.
    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] opc,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] r;
        case (opc)
            2'b00:   r = m;
            2'b01:   r = cur & ~m;
            2'b10:   r = cur | m;
            2'b11:   r = cur ^ m;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Successor index with wrap at N_REQ (N_REQ need not be a power of two).
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        logic [OW-1:0] r;
        if (i == OW'(N_REQ - 1)) begin
            r = {OW{1'b0}};
        end else begin
            r = i + OW'(1);
        end
        return r;
    endfunction

    // Split the flattened per-requester opcode and data buses into arrays.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_s[i] = op[2*i +: 2];
            wd_s[i] = wdata[WIDTH*i +: WIDTH];
        end
    end

    // Find the first requesting index at or after ptr, wrapping around.
    always_comb begin
        logic [OW:0] sum;
        found_s = 1'b0;
        win_s   = ptr_q;
        sum     = {(OW+1){1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sum     = {1'b0, ptr_q} + (OW+1)'(i);
            sum     = (sum >= (OW+1)'(N_REQ)) ? (sum - (OW+1)'(N_REQ)) : sum;
            win_s   = (!found_s && req[sum[OW-1:0]]) ? sum[OW-1:0] : win_s;
            found_s = found_s | req[sum[OW-1:0]];
        end
    end

    // Next-state logic: grant, bank update, pointer rotation and lock handling.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        q_d      = q_q;
        gnt_d    = {N_REQ{1'b0}};
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    q_d     = apply_op(op_s[win_s], q_q, wd_s[win_s]);
                    gnt_d   = N_REQ'(1) << win_s;
                    owner_d = win_s;
                    ptr_d   = next_idx(win_s);
                    state_d = lock[win_s] ? LOCKED : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                // Only the owner is served; the pointer stays frozen until release.
                if (req[owner_q]) begin
                    q_d   = apply_op(op_s[owner_q], q_q, wd_s[owner_q]);
                    gnt_d = N_REQ'(1) << owner_q;
                end else begin
                    q_d   = q_q;
                end
                if (!lock[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= {OW{1'b0}};
            owner_q  <= {OW{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            gnt_q    <= {N_REQ{1'b0}};
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            q_q      <= q_d;
            gnt_q    <= gnt_d;
            locked_q <= locked_d;
        end
    end

    assign gnt    = gnt_q;
    assign q      = q_q;
    assign owner  = owner_q;
    assign locked = locked_q;

endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

Round-robin arbiter and sequencer for a shared WIDTH-bit flip-flop register bank. Up to N_REQ requesters issue bit-wise operations using D, SR and T semantics: load, clear-mask, set-mask and toggle-mask. The block grants one requester per cycle and applies the winning operation to the bank. A requester may lock the bank for a multi-cycle burst. It sits between the control agents and the shared status/flag register, so no requester drives the flip-flops directly.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 8: register bank width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request, level.
- lock  in  N_REQ  per-requester lock request; sampled only with that requester's req or while it owns the bank.
- op  in  2*N_REQ  per-requester opcode, requester i at [2i+1:2i]:
  - 00 load, q <= wdata.
  - 01 clear, q <= q & ~wdata.
  - 10 set, q <= q | wdata.
  - 11 toggle, q <= q ^ wdata.
- wdata  in  WIDTH*N_REQ  per-requester data/mask, requester i at [WIDTH*i+WIDTH-1:WIDTH*i].
- gnt  out  N_REQ  registered one-hot; requester whose op was applied at the last edge, else 0.
- q  out  WIDTH  register bank contents.
- owner  out  clog2(N_REQ) (min 1)  index of last granted requester.
- locked  out  1  high while the FSM is in LOCKED.

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - Each edge, if any req is high, pick the first requester at or after rotating pointer ptr (wrapping at N_REQ).
  - Apply its op to q and set gnt to its one-hot.
  - Set owner to its index and ptr to (winner+1) mod N_REQ.
  - If the winner's lock is high, go to LOCKED.
  - No req: gnt=0; q, ptr, owner hold.
- LOCKED:
  - Only requester owner is served; all other req are ignored and ptr is frozen.
  - Edge with req[owner]=1: apply op[owner], gnt=one-hot(owner).
  - Edge with req[owner]=0: no op, gnt=0.
  - Edge with lock[owner]=0: leave to IDLE after this edge's action; ptr = (owner+1) mod N_REQ.
- Ops are bit-wise and independent per bit; there is no invalid opcode. SR 11 is not represented; toggle covers JK 11.
- Only one op is applied per edge. There are no simultaneous writes.
- Reset (rst low, asynchronous, any state, including mid-lock):
  - q=0, gnt=0, owner=0, ptr=0, locked=0, state IDLE.
  - In-flight op is discarded.

## Timing
- Latency: req/op/wdata sampled at edge k; q update, gnt and owner are all visible after edge k (same cycle). Worst-case grant latency in IDLE is N_REQ cycles, excluding locks.
- Handshake: requester holds req/op/wdata stable until it sees its gnt bit. It then either drops req or presents the next op; if req is still high it is re-arbitrated normally.
- A requester whose lock is high wins and keeps the bank on back-to-back edges with no idle cycle.
- gnt is a pulse per applied op, never multi-hot. Outputs are registered with no combinational path from inputs.
- Reset release: first arbitration happens on the first rising edge with rst high; ptr starts at 0.

## Test plan
- Reset: drive q to 0xA5, then pull rst low mid-cycle -> q=0x00, gnt=0, locked=0 before the next edge; hold all through release.
- Op semantics, req0 alone, one op per cycle:
  - load 0xA5 -> q=0xA5, gnt=0001.
  - set 0x0F -> 0xAF.
  - clear 0xA0 -> 0x0F.
  - toggle 0xFF -> 0xF0.
- Round robin: req=1111 held, requester i loads 0x10+i, ptr=0 -> gnt sequence 0001,0010,0100,1000,0001; q=0x10,0x11,0x12,0x13,0x10.
- Lock burst: req1 with lock=1, toggle 0x01, plus req2/req3 held:
  - gnt=0010 for 3 cycles, q alternating bit0, locked=1.
  - Drop lock1 -> one final op, then gnt=0100 next edge.
- Lock idle: owner 2 locks, then drops req but keeps lock=1 while req0 is high -> gnt=0000, q holds, locked=1. Dropping lock2 -> gnt=0001 after one edge, with ptr from 3.
- Reset during lock: in LOCKED with owner=3, assert rst -> locked=0, ptr=0. After release with req=1111, first gnt=0001.
